// File: rtl/apb_pkg.sv
// Shared types and widths for the APB master bridge and its address decoder.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a CPU byte address onto one slave window: index, mapped flag and one-hot select.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                    NUM_SLAVES    = 4,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR     = 32'h1000_0000,
    parameter int                    SLV_SPAN_LOG2 = 12,
    localparam int                   IDX_W         = idx_width(NUM_SLAVES)
) (
    input  logic [APB_ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]      idx,
    output logic                  mapped,
    output logic [NUM_SLAVES-1:0] sel
);

    logic [APB_ADDR_W-1:0] off;
    logic [APB_ADDR_W-1:0] slot;

    // The addr >= BASE_ADDR term keeps addresses below the window from
    // wrapping around through the subtraction into a valid slot.
    always_comb begin
        off    = addr - BASE_ADDR;
        slot   = off >> SLV_SPAN_LOG2;
        mapped = (addr >= BASE_ADDR) && (slot < APB_ADDR_W'(NUM_SLAVES));
        idx    = mapped ? slot[IDX_W-1:0] : '0;
        sel    = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = mapped && (slot == APB_ADDR_W'(i));
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-master APB bridge: latches one CPU request, runs SETUP/ACCESS on the
// decoded slave and returns a registered one-cycle completion with data or error.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int                    NUM_SLAVES    = 4,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR     = 32'h1000_0000,
    parameter int                    SLV_SPAN_LOG2 = 12,
    parameter int                    TIMEOUT       = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             transfer,
    input  logic                             write,
    input  logic [APB_ADDR_W-1:0]            addr,
    input  logic [APB_DATA_W-1:0]            wdata,
    output logic [APB_DATA_W-1:0]            rdata,
    output logic                             ready,
    output logic                             err,
    output logic [APB_ADDR_W-1:0]            PADDR,
    output logic [APB_DATA_W-1:0]            PWDATA,
    output logic                             PWRITE,
    output logic                             PENABLE,
    output logic [NUM_SLAVES-1:0]            PSEL,
    input  logic [NUM_SLAVES*APB_DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY
);

    localparam int IDX_W = idx_width(NUM_SLAVES);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_state_t state_q;
    apb_state_t state_d;

    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_mapped;
    logic [NUM_SLAVES-1:0] dec_sel;

    logic [IDX_W-1:0]      idx_q;
    logic [NUM_SLAVES-1:0] sel_q;
    logic [CNT_W-1:0]      tcnt_q;

    logic                  accept;
    logic                  bad_addr;
    logic                  done;
    logic                  abort;
    logic                  sel_pready;
    logic                  timeout_hit;
    logic [APB_DATA_W-1:0] slot_rdata;

    apb_addr_decoder #(
        .NUM_SLAVES    (NUM_SLAVES),
        .BASE_ADDR     (BASE_ADDR),
        .SLV_SPAN_LOG2 (SLV_SPAN_LOG2)
    ) u_decoder (
        .addr   (addr),
        .idx    (dec_idx),
        .mapped (dec_mapped),
        .sel    (dec_sel)
    );

    always_comb begin
        slot_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slot_rdata = PRDATA[i*APB_DATA_W +: APB_DATA_W];
            end
        end
    end

    // tcnt_q counts ACCESS cycles already completed, so the abort fires in the
    // TIMEOUT-th ACCESS cycle when the slave is still not ready.
    assign sel_pready  = |(PREADY & sel_q);
    assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == CNT_W'(TIMEOUT - 1));

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        bad_addr = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        PSEL     = '0;
        PENABLE  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    accept = 1'b1;
                    if (dec_mapped) state_d = SETUP;
                    else            bad_addr = 1'b1;
                end
            end
            SETUP: begin
                PSEL    = sel_q;
                state_d = ACCESS;
            end
            ACCESS: begin
                PSEL    = sel_q;
                PENABLE = 1'b1;
                if (sel_pready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request fields hold their last value until the next accepted request.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
            idx_q  <= '0;
            sel_q  <= '0;
        end else if (accept) begin
            PADDR  <= addr;
            PWDATA <= wdata;
            PWRITE <= write;
            idx_q  <= dec_idx;
            sel_q  <= dec_sel;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)                 tcnt_q <= '0;
        else if (state_q == ACCESS) tcnt_q <= tcnt_q + 1'b1;
        else                        tcnt_q <= '0;
    end

    // Completion is one registered cycle; err/rdata are zero outside it.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= bad_addr | done | abort;
            err   <= bad_addr | abort;
            rdata <= (done && !PWRITE) ? slot_rdata : '0;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed plan steps, then randomized
// requests against a transaction-level model of four slave behaviours.
module tb_apb_master_bridge;

    localparam int          NS   = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          TO   = 16;

    logic          PCLK     = 1'b0;
    logic          PRESET   = 1'b0;
    logic          transfer = 1'b0;
    logic          write    = 1'b0;
    logic [31:0]   addr     = '0;
    logic [31:0]   wdata    = '0;
    logic [31:0]   rdata;
    logic          ready;
    logic          err;
    logic [31:0]   PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PENABLE;
    logic [NS-1:0] PSEL;
    logic [NS*32-1:0] PRDATA;
    logic [NS-1:0] PREADY;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .NUM_SLAVES    (NS),
        .BASE_ADDR     (BASE),
        .SLV_SPAN_LOG2 (12),
        .TIMEOUT       (TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    // Slot 0: timer with registered PREADY and four registers (PSC at offset 8).
    logic [31:0] timer_regs [4] = '{default: '0};
    logic        timer_rdy;
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) timer_rdy <= 1'b0;
        else        timer_rdy <= PSEL[0] & PENABLE & ~timer_rdy;
    end
    always @(posedge PCLK) begin
        if (PSEL[0] & PENABLE & timer_rdy & PWRITE) timer_regs[PADDR[3:2]] <= PWDATA;
    end

    // Slot 3: memory with w3 wait states in ACCESS.
    logic [31:0] mem3 [16] = '{default: '0};
    int acc3 = 0;
    int w3   = 0;
    always @(posedge PCLK) begin
        if (PSEL[3] & PENABLE) acc3 <= acc3 + 1;
        else                   acc3 <= 0;
        if (PSEL[3] & PENABLE & PREADY[3] & PWRITE) mem3[PADDR[5:2]] <= PWDATA;
    end

    // Slot 1 is zero-wait with fixed data; slot 2 never answers.
    assign PREADY = {PSEL[3] & PENABLE & (acc3 == w3), 1'b0, 1'b1, timer_rdy};
    assign PRDATA = {mem3[PADDR[5:2]], 32'hBAD0_BAD0, 32'hDEAD_BEEF, timer_regs[PADDR[3:2]]};

    // Reference model state: what each slave should hold after completed writes.
    logic [31:0] exp_timer [4]  = '{default: '0};
    logic [31:0] exp_mem3  [16] = '{default: '0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one request starting in the current cycle; ends at the negedge of its
    // ready cycle. mode 0: drop transfer, 1: hold it high, 2: random ignored pulses.
    task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int mode);
        logic          in_range;
        int            slot;
        int            n;
        int            lat;
        logic          exp_err;
        logic [31:0]   exp_rd;
        logic [NS-1:0] exp_sel;
        in_range = (a >= BASE) && (((a - BASE) / 32'd4096) < 32'(NS));
        slot     = in_range ? int'((a - BASE) / 32'd4096) : -1;
        n        = 0;
        exp_err  = 1'b1;
        exp_rd   = '0;
        case (slot)
            0: begin n = 2;      exp_err = 1'b0; exp_rd = wr ? 32'h0 : exp_timer[a[3:2]]; end
            1: begin n = 1;      exp_err = 1'b0; exp_rd = wr ? 32'h0 : 32'hDEAD_BEEF;     end
            2: begin n = TO;     exp_err = 1'b1; exp_rd = '0;                             end
            3: begin n = w3 + 1; exp_err = 1'b0; exp_rd = wr ? 32'h0 : exp_mem3[a[5:2]];  end
            default: ;
        endcase
        lat     = in_range ? n + 2 : 1;
        exp_sel = in_range ? (NS'(1) << slot) : '0;

        for (int k = 0; k <= lat; k++) begin
            if (k == 0) begin
                transfer = 1'b1;
                write    = wr;
                addr     = a;
                wdata    = wd;
            end else if (k < lat && mode == 2) begin
                transfer = 1'($urandom_range(0, 1));
                write    = 1'($urandom_range(0, 1));
                addr     = BASE + 32'h1000 + ($urandom & 32'hFFC);
                wdata    = $urandom;
            end else if (mode != 1) begin
                transfer = 1'b0;
            end
            if (k > 0) begin
                @(negedge PCLK);
                if (k < lat) begin
                    check("busy_ready",   32'(ready),    32'h0);
                    check("busy_psel",    32'(PSEL),     32'(exp_sel));
                    check("busy_penable", 32'(PENABLE),  32'(k >= 2));
                    check("busy_paddr",   PADDR,         a);
                    check("busy_pwdata",  PWDATA,        wd);
                    check("busy_pwrite",  32'(PWRITE),   32'(wr));
                end else begin
                    check("done_ready",   32'(ready),    32'h1);
                    check("done_err",     32'(err),      32'(exp_err));
                    check("done_rdata",   rdata,         exp_rd);
                    check("done_psel",    32'(PSEL),     32'h0);
                    check("done_penable", 32'(PENABLE),  32'h0);
                    check("done_paddr",   PADDR,         a);
                end
            end
            if (k < lat) begin
                @(posedge PCLK);
                #1;
            end
        end

        if (!exp_err && wr) begin
            if (slot == 0) exp_timer[a[3:2]] = wd;
            if (slot == 3) exp_mem3[a[5:2]]  = wd;
        end
    endtask

    task automatic idle(input int n);
        transfer = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK);
            #1;
            @(negedge PCLK);
            check("idle_ready", 32'(ready), 32'h0);
            check("idle_psel",  32'(PSEL),  32'h0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psel"},    32'(PSEL),    32'h0);
        check({tag, "_penable"}, 32'(PENABLE), 32'h0);
        check({tag, "_ready"},   32'(ready),   32'h0);
        check({tag, "_err"},     32'(err),     32'h0);
        check({tag, "_rdata"},   rdata,        32'h0);
        check({tag, "_paddr"},   PADDR,        32'h0);
        check({tag, "_pwdata"},  PWDATA,       32'h0);
        check({tag, "_pwrite"},  32'(PWRITE),  32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int          pick;
        int          gap;

        // Power-on reset.
        #1 PRESET = 1'b1;
        #2 check_all_zero("reset");
        @(posedge PCLK);
        #3 PRESET = 1'b0;
        @(negedge PCLK);

        // Timer write through registered-PREADY slot 0.
        txn(1'b1, 32'h1000_0008, 32'h0000_00FF, 0);
        check("timer_psc", timer_regs[2], 32'h0000_00FF);
        idle(1);

        // Zero-wait read from slot 1.
        txn(1'b0, 32'h1000_1004, 32'h0, 0);
        idle(1);

        // Unmapped: above the last window, then below the base.
        txn(1'b0, 32'h1000_4000, 32'h0, 0);
        txn(1'b0, 32'h0FFF_FFFC, 32'h0, 0);
        idle(1);

        // Slot 2 never answers; a following request to slot 0 still completes.
        txn(1'b0, 32'h1000_2000, 32'h0, 0);
        txn(1'b1, 32'h1000_000C, 32'h1234_5678, 0);
        idle(1);

        // Transfer held high: second read accepted in the first one's ready cycle.
        txn(1'b0, 32'h1000_0008, 32'h0, 1);
        txn(1'b0, 32'h1000_1000, 32'h0, 1);
        idle(1);

        // Ignored transfer pulses during a waited slot-3 write, then read back.
        w3 = 3;
        txn(1'b1, 32'h1000_3010, 32'hCAFE_F00D, 2);
        txn(1'b0, 32'h1000_3010, 32'h0, 2);
        idle(1);

        // Reset in the middle of ACCESS drops the transfer without a ready pulse.
        transfer = 1'b1;
        write    = 1'b0;
        addr     = 32'h1000_2004;
        @(posedge PCLK);
        #1 transfer = 1'b0;
        @(posedge PCLK);
        #1;
        @(posedge PCLK);
        #1;
        check("pre_reset_penable", 32'(PENABLE), 32'h1);
        #2 PRESET = 1'b1;
        #1 check_all_zero("mid_reset");
        #2 PRESET = 1'b0;
        idle(TO + 4);
        txn(1'b0, 32'h1000_0008, 32'h0, 0);
        idle(1);

        // Randomized requests across all slot kinds and unmapped regions.
        for (int t = 0; t < 60; t++) begin
            pick = int'($urandom_range(0, 6));
            case (pick)
                0, 1, 2, 3: a = BASE + (32'(pick) << 12) + ($urandom & 32'hFFC);
                4:          a = 32'h1000_4000 + ($urandom & 32'h0FFF_FFFC);
                5:          a = ($urandom % BASE) & 32'hFFFF_FFFC;
                default:    a = 32'hFFFF_F000 | ($urandom & 32'hFFC);
            endcase
            w3 = int'($urandom_range(0, 4));
            txn(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)));
            gap = int'($urandom_range(0, 2));
            idle(gap);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
